// File: rtl/hv_cmd_scheduler.sv
// HV command scheduler: latches configure / on / off requests,
// prioritises them and sequences trigger, byte count, timeout and gap.
module hv_cmd_scheduler #(
  parameter int PULSE_LEN      = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CFG_BYTES      = 12,
  parameter int SS_BYTES       = 8
) (
  input  logic        Clk_In,
  input  logic        Rst_N,
  input  logic        Req_Cfg,
  input  logic [55:0] In_Hv_7Byte,
  input  logic        Req_On,
  input  logic        Req_Off,
  input  logic        Clr_Err,
  input  logic        In_Cmd_En,
  output logic        Out_Start_Cfg,
  output logic        Out_Start_Stop,
  output logic        Out_Flag_Start,
  output logic [55:0] Out_Hv_7Byte,
  output logic        Busy,
  output logic        Done,
  output logic        Err_Timeout
);

  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW   = $clog2(GAP_CYCLES + 1);
  localparam int PW   = $clog2(PULSE_LEN + 1);
  localparam int BMAX = (CFG_BYTES > SS_BYTES) ? CFG_BYTES : SS_BYTES;
  localparam int BW   = $clog2(BMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, WAIT, GAP
  } state_e;

  state_e        state_q, state_d;
  logic          pend_cfg_q, pend_cfg_d;
  logic          pend_ss_q, pend_ss_d;
  logic          pend_flag_q, pend_flag_d;
  logic [55:0]   hv_pend_q, hv_pend_d;
  logic          cur_cfg_q, cur_cfg_d;
  logic [55:0]   hv_out_q, hv_out_d;
  logic          flag_q, flag_d;
  logic [PW-1:0] pls_q, pls_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [BW-1:0] byte_q, byte_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q;

  logic          acc_off, acc_cfg, acc_on;
  logic          err_set;
  logic [BW-1:0] exp_b;

  // Next-state, acceptance, counters and pending capture
  always_comb begin
    state_d     = state_q;
    pend_cfg_d  = pend_cfg_q;
    pend_ss_d   = pend_ss_q;
    pend_flag_d = pend_flag_q;
    hv_pend_d   = hv_pend_q;
    cur_cfg_d   = cur_cfg_q;
    hv_out_d    = hv_out_q;
    flag_d      = flag_q;
    pls_d       = pls_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    byte_d      = byte_q;
    done_d      = 1'b0;
    err_set     = 1'b0;
    acc_off     = 1'b0;
    acc_cfg     = 1'b0;
    acc_on      = 1'b0;
    exp_b       = cur_cfg_q ? BW'(CFG_BYTES) : BW'(SS_BYTES);

    if ((state_q == PULSE || state_q == WAIT) &&
        In_Cmd_En && byte_q != exp_b)
      byte_d = byte_q + BW'(1);

    unique case (state_q)
      IDLE: begin
        if (pend_ss_q && !pend_flag_q) acc_off = 1'b1;
        else if (pend_cfg_q)           acc_cfg = 1'b1;
        else if (pend_ss_q)            acc_on  = 1'b1;
        if (acc_off || acc_cfg || acc_on) begin
          state_d   = SETUP;
          cur_cfg_d = acc_cfg;
          if (acc_cfg) hv_out_d = hv_pend_q;
          else         flag_d   = pend_flag_q;
          byte_d = '0;
          pls_d  = '0;
          tmo_d  = '0;
        end
      end
      SETUP: begin
        state_d = PULSE;
        pls_d   = '0;
        tmo_d   = '0;
      end
      PULSE: begin
        tmo_d = tmo_q + TW'(1);
        pls_d = pls_q + PW'(1);
        if (pls_q == PW'(PULSE_LEN - 1)) state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (byte_d == exp_b) begin
          done_d  = 1'b1;
          state_d = GAP;
          gap_d   = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_set = 1'b1;
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (acc_cfg)          pend_cfg_d = 1'b0;
    if (acc_off || acc_on) pend_ss_d = 1'b0;
    if (Req_Cfg) begin
      pend_cfg_d = 1'b1;
      hv_pend_d  = In_Hv_7Byte;
    end
    if (Req_On || Req_Off) begin
      pend_ss_d   = 1'b1;
      pend_flag_d = ~Req_Off;
    end

    if (err_set)      err_d = 1'b1;
    else if (Clr_Err) err_d = 1'b0;
    else              err_d = err_q;
  end

  // State, pending and output registers
  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q     <= IDLE;
      pend_cfg_q  <= 1'b0;
      pend_ss_q   <= 1'b0;
      pend_flag_q <= 1'b0;
      hv_pend_q   <= '0;
      cur_cfg_q   <= 1'b0;
      hv_out_q    <= '0;
      flag_q      <= 1'b0;
      pls_q       <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      byte_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_cfg_q  <= pend_cfg_d;
      pend_ss_q   <= pend_ss_d;
      pend_flag_q <= pend_flag_d;
      hv_pend_q   <= hv_pend_d;
      cur_cfg_q   <= cur_cfg_d;
      hv_out_q    <= hv_out_d;
      flag_q      <= flag_d;
      pls_q       <= pls_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      byte_q      <= byte_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign Out_Start_Cfg  = (state_q == PULSE) && cur_cfg_q;
  assign Out_Start_Stop = (state_q == PULSE) && !cur_cfg_q;
  assign Out_Flag_Start = flag_q;
  assign Out_Hv_7Byte   = hv_out_q;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign Err_Timeout    = err_q;

endmodule

// File: tb/tb_hv_cmd_scheduler.sv
// Directed bench for hv_cmd_scheduler: a small builder model returns
// strobes; timing, ordering, timeout and reset are checked.
module tb_hv_cmd_scheduler;

  logic        Clk_In = 1'b0;
  logic        Rst_N = 1'b0;
  logic        Req_Cfg = 1'b0;
  logic [55:0] In_Hv_7Byte = '0;
  logic        Req_On = 1'b0;
  logic        Req_Off = 1'b0;
  logic        Clr_Err = 1'b0;
  logic        In_Cmd_En = 1'b0;
  logic        Out_Start_Cfg;
  logic        Out_Start_Stop;
  logic        Out_Flag_Start;
  logic [55:0] Out_Hv_7Byte;
  logic        Busy;
  logic        Done;
  logic        Err_Timeout;

  localparam logic [55:0] HV_1 = 56'h30_31_32_33_2E_35_30;
  localparam logic [55:0] HV_A = 56'h31_32_33_34_2E_30_30;
  localparam logic [55:0] HV_B = 56'h32_30_30_30_2E_35_30;
  localparam logic [55:0] HV_C = 56'h30_30_35_30_2E_32_35;
  localparam logic [55:0] HV_D = 56'h30_39_39_39_2E_39_39;
  localparam logic [55:0] HV_E = 56'h31_30_30_30_2E_30_31;

  int checks = 0;
  int errors = 0;

  hv_cmd_scheduler dut (
    .Clk_In         (Clk_In),
    .Rst_N          (Rst_N),
    .Req_Cfg        (Req_Cfg),
    .In_Hv_7Byte    (In_Hv_7Byte),
    .Req_On         (Req_On),
    .Req_Off        (Req_Off),
    .Clr_Err        (Clr_Err),
    .In_Cmd_En      (In_Cmd_En),
    .Out_Start_Cfg  (Out_Start_Cfg),
    .Out_Start_Stop (Out_Start_Stop),
    .Out_Flag_Start (Out_Flag_Start),
    .Out_Hv_7Byte   (Out_Hv_7Byte),
    .Busy           (Busy),
    .Done           (Done),
    .Err_Timeout    (Err_Timeout)
  );

  always #5 Clk_In = ~Clk_In;

  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input bit cfg, input bit on, input bit off,
                     input logic [55:0] hv);
    Req_Cfg = cfg;
    Req_On = on;
    Req_Off = off;
    In_Hv_7Byte = hv;
    tick();
    Req_Cfg = 1'b0;
    Req_On = 1'b0;
    Req_Off = 1'b0;
  endtask

  task automatic no_more(input string tag);
    int b;
    b = 0;
    repeat (30) begin
      tick();
      if (Busy || Out_Start_Cfg || Out_Start_Stop) b++;
    end
    chk(tag, b, 0);
  endtask

  // inj: 0 none, 1 Req_On then Req_Off two cycles later,
  // 2 Req_Cfg with HV_A then HV_B two cycles later
  task automatic run_cmd(input string tag, input bit is_cfg,
                         input bit flag, input logic [55:0] hv,
                         input int nstb, input bit exp_done,
                         input int inj);
    int n, c, cfg_hi, ss_hi, bad, dn, since, err_t;
    logic [55:0] p_hv;
    logic p_flag, p_err;
    n = 0;
    p_hv = Out_Hv_7Byte;
    p_flag = Out_Flag_Start;
    while (!(Out_Start_Cfg || Out_Start_Stop) && n < 100) begin
      p_hv = Out_Hv_7Byte;
      p_flag = Out_Flag_Start;
      tick();
      n++;
    end
    chk({tag, "_rise"}, 64'(n < 100), 1);
    chk({tag, "_pre"}, is_cfg ? p_hv : {55'd0, p_flag},
        is_cfg ? hv : {55'd0, flag});
    c = 0; cfg_hi = 0; ss_hi = 0; bad = 0;
    dn = 0; since = -1; err_t = -1;
    p_err = Err_Timeout;
    while ((c < nstb + 4 || Busy) && c < 1300) begin
      if (Out_Start_Cfg) cfg_hi++;
      if (Out_Start_Stop) ss_hi++;
      if (is_cfg ? (Out_Hv_7Byte !== hv) : (Out_Flag_Start !== flag))
        bad++;
      In_Cmd_En = (c >= 2 && c < 2 + nstb);
      Req_On = (inj == 1 && c == 6);
      Req_Off = (inj == 1 && c == 8);
      Req_Cfg = (inj == 2 && (c == 6 || c == 8));
      In_Hv_7Byte = (c == 6) ? HV_A : HV_B;
      tick();
      c++;
      if (Done) begin
        dn++;
        since = 0;
      end else if (Err_Timeout && !p_err) begin
        since = 0;
        if (err_t < 0) err_t = c;
      end else if (since >= 0) begin
        since++;
      end
      p_err = Err_Timeout;
    end
    In_Cmd_En = 1'b0;
    Req_On = 1'b0;
    Req_Off = 1'b0;
    Req_Cfg = 1'b0;
    chk({tag, "_cfg_hi"}, cfg_hi, is_cfg ? 4 : 0);
    chk({tag, "_ss_hi"}, ss_hi, is_cfg ? 0 : 4);
    chk({tag, "_stable"}, bad, 0);
    chk({tag, "_done"}, dn, exp_done ? 1 : 0);
    chk({tag, "_err_t"}, err_t, exp_done ? -1 : 1023);
    chk({tag, "_gap"}, since, 16);
    chk({tag, "_idle"}, Busy, 0);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("reset_outs", {Out_Start_Cfg, Out_Start_Stop, Out_Flag_Start,
        Busy, Done, Err_Timeout, Out_Hv_7Byte}, 0);
    Rst_N = 1'b1;
    tick();
    chk("post_reset", {Out_Start_Cfg, Out_Start_Stop, Out_Flag_Start,
        Busy, Done, Err_Timeout, Out_Hv_7Byte}, 0);

    req(1, 0, 0, HV_1);
    run_cmd("t1", 1, 0, HV_1, 12, 1, 0);
    chk("t1_err", Err_Timeout, 0);

    req(1, 0, 0, HV_E);
    run_cmd("t2a", 1, 0, HV_E, 12, 1, 1);
    run_cmd("t2b", 0, 0, HV_E, 8, 1, 0);
    no_more("t2_single");

    req(1, 0, 1, HV_C);
    run_cmd("t3off", 0, 0, HV_C, 10, 1, 0);
    run_cmd("t3cfg", 1, 0, HV_C, 12, 1, 0);
    no_more("t3_end");

    req(1, 0, 0, HV_D);
    run_cmd("t4", 1, 0, HV_D, 5, 0, 0);
    chk("t4_err", Err_Timeout, 1);

    req(1, 0, 0, HV_C);
    run_cmd("t5a", 1, 0, HV_C, 12, 1, 2);
    run_cmd("t5b", 1, 0, HV_B, 12, 1, 0);
    no_more("t5_single");
    chk("t5_err_sticky", Err_Timeout, 1);
    Clr_Err = 1'b1;
    tick();
    Clr_Err = 1'b0;
    chk("clr_err", Err_Timeout, 0);

    req(1, 0, 0, HV_D);
    n = 0;
    while (!Out_Start_Cfg && n < 100) begin
      tick();
      n++;
    end
    chk("t6_rise", 64'(n < 100), 1);
    repeat (5) tick();
    In_Cmd_En = 1'b1;
    repeat (3) tick();
    In_Cmd_En = 1'b0;
    Req_On = 1'b1;
    tick();
    Req_On = 1'b0;
    chk("t6_busy_pre", Busy, 1);
    Rst_N = 1'b0;
    #1;
    chk("t6_reset_outs", {Out_Start_Cfg, Out_Start_Stop, Out_Flag_Start,
        Busy, Done, Err_Timeout, Out_Hv_7Byte}, 0);
    repeat (2) tick();
    Rst_N = 1'b1;
    no_more("t6_no_cmd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
